jtag_tap_multi: RTL

Parametrised IEEE 1149.1 test-access port: 16-state TAP controller, instruction register, bypass and IDCODE registers, boundary-scan control outputs, and NUM_USER user data registers with parallel capture/update ports. It replaces the fixed 4-instruction test logic in the chip's JTAG slice. It is the single TAP between the board pins and every on-die scan chain and debug register. All state is clocked by tck only.

---
 rtl/jtag_tap_multi.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/jtag_tap_multi.sv
// IEEE 1149.1 test-access port: TAP controller, IR, BYPASS/IDCODE, boundary-scan controls
// and NUM_USER user data registers with parallel capture/update ports. Clocked by tck only.
//
//  state      | meaning
//  TLR   (F)  | test-logic-reset, active IR held at IDCODE
//  RTI   (C)  | run-test/idle
//  SelDR (7)  | select DR scan
//  CapDR (6)  | selected DR captures parallel data
//  ShDR  (2)  | selected DR shifts tdi -> tdo
//  Ex1DR (1)  | exit-1 DR
//  PauseDR(3) | DR shift paused, contents held
//  Ex2DR (0)  | exit-2 DR
//  UpdDR (5)  | DR update (user_upd load, strobe)
//  SelIR (4)  | select IR scan
//  CapIR (E)  | IR shift register loads 0..01
//  ShIR  (A)  | IR shifts tdi -> tdo
//  Ex1IR (9)  | exit-1 IR
//  PauseIR(B) | IR shift paused
//  Ex2IR (8)  | exit-2 IR
//  UpdIR (D)  | active IR loads on the edge leaving this state
module jtag_tap_multi #(
    parameter int          IR_WIDTH   = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0CAF,
    parameter int          NUM_USER   = 2,
    parameter int          USER_WIDTH = 8,
    parameter int          USER_BASE  = 8
) (
    input  logic                           tck,
    input  logic                           trst,
    input  logic                           tms,
    input  logic                           tdi,
    output logic                           tdo,
    output logic                           tdo_en,
    output logic [3:0]                     tap_state,
    output logic                           bsr_tdi,
    input  logic                           bsr_tdo,
    output logic                           bsr_capture,
    output logic                           bsr_shift,
    output logic                           bsr_update,
    output logic                           bsr_mode,
    input  logic [NUM_USER*USER_WIDTH-1:0] user_cap,
    output logic [NUM_USER*USER_WIDTH-1:0] user_upd,
    output logic [NUM_USER-1:0]            user_upd_stb
);
    localparam logic [3:0] TLR = 4'hF, RTI = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6;
    localparam logic [3:0] SH_DR = 4'h2, EX1_DR = 4'h1, PAUSE_DR = 4'h3, EX2_DR = 4'h0;
    localparam logic [3:0] UPD_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR = 4'hA;
    localparam logic [3:0] EX1_IR = 4'h9, PAUSE_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD;

    localparam logic [IR_WIDTH-1:0] OP_EXTEST = '0;
    localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(2);
    localparam logic [IR_WIDTH-1:0] OP_BYPASS = '1;

    logic [3:0]            state, next_state;
    logic [IR_WIDTH-1:0]   ir, ir_sr;
    logic                  bypass_sr;
    logic [31:0]           idcode_sr;
    logic [USER_WIDTH-1:0] user_sr, user_cap_sel;
    logic [NUM_USER-1:0]   user_sel;
    logic                  fixed_op, sel_idcode, sel_bsr, user_hit, dr_lsb;

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) state <= TLR;
        else       state <= next_state;
    end

    always_comb begin
        next_state = TLR;
        case (state)
            TLR:      next_state = tms ? TLR    : RTI;
            RTI:      next_state = tms ? SEL_DR : RTI;
            SEL_DR:   next_state = tms ? SEL_IR : CAP_DR;
            CAP_DR:   next_state = tms ? EX1_DR : SH_DR;
            SH_DR:    next_state = tms ? EX1_DR : SH_DR;
            EX1_DR:   next_state = tms ? UPD_DR : PAUSE_DR;
            PAUSE_DR: next_state = tms ? EX2_DR : PAUSE_DR;
            EX2_DR:   next_state = tms ? UPD_DR : SH_DR;
            UPD_DR:   next_state = tms ? SEL_DR : RTI;
            SEL_IR:   next_state = tms ? TLR    : CAP_IR;
            CAP_IR:   next_state = tms ? EX1_IR : SH_IR;
            SH_IR:    next_state = tms ? EX1_IR : SH_IR;
            EX1_IR:   next_state = tms ? UPD_IR : PAUSE_IR;
            PAUSE_IR: next_state = tms ? EX2_IR : PAUSE_IR;
            EX2_IR:   next_state = tms ? UPD_IR : SH_IR;
            UPD_IR:   next_state = tms ? SEL_DR : RTI;
            default:  next_state = TLR;
        endcase
    end

    // Fixed opcodes win over any user opcode that happens to alias them.
    always_comb begin
        fixed_op     = (ir == OP_BYPASS) || (ir == OP_IDCODE) || (ir == OP_SAMPLE) || (ir == OP_EXTEST);
        sel_idcode   = (ir == OP_IDCODE);
        sel_bsr      = (ir == OP_SAMPLE) || (ir == OP_EXTEST);
        user_sel     = '0;
        user_cap_sel = '0;
        for (int k = 0; k < NUM_USER; k++) begin
            if (!fixed_op && (ir == IR_WIDTH'(USER_BASE + k))) begin
                user_sel[k]  = 1'b1;
                user_cap_sel = user_cap[k*USER_WIDTH +: USER_WIDTH];
            end
        end
        user_hit = |user_sel;
    end

    always_comb begin
        dr_lsb = bypass_sr;
        if (sel_idcode)    dr_lsb = idcode_sr[0];
        else if (sel_bsr)  dr_lsb = bsr_tdo;
        else if (user_hit) dr_lsb = user_sr[0];
    end

    always_comb begin
        tap_state    = state;
        bsr_tdi      = tdi;
        bsr_mode     = (ir == OP_EXTEST);
        bsr_capture  = sel_bsr && (state == CAP_DR);
        bsr_shift    = sel_bsr && (state == SH_DR);
        bsr_update   = sel_bsr && (state == UPD_DR);
        user_upd_stb = (state == UPD_DR) ? user_sel : '0;
    end

    // Entering TLR by tms loads IDCODE on that same edge so TLR never shows a stale IR.
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            ir_sr <= '0;
            ir    <= OP_IDCODE;
        end else begin
            if (state == CAP_IR)     ir_sr <= IR_WIDTH'(1);
            else if (state == SH_IR) ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
            if (next_state == TLR)   ir <= OP_IDCODE;
            else if (state == UPD_IR) ir <= ir_sr;
        end
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            bypass_sr <= 1'b0;
            idcode_sr <= '0;
            user_sr   <= '0;
            user_upd  <= '0;
        end else begin
            if (state == CAP_DR) begin
                bypass_sr <= 1'b0;
                if (sel_idcode) idcode_sr <= IDCODE_VAL;
                if (user_hit)   user_sr   <= user_cap_sel;
            end else if (state == SH_DR) begin
                bypass_sr <= tdi;
                if (sel_idcode) idcode_sr <= {tdi, idcode_sr[31:1]};
                if (user_hit)   user_sr   <= {tdi, user_sr[USER_WIDTH-1:1]};
            end
            for (int k = 0; k < NUM_USER; k++) begin
                if ((state == UPD_DR) && user_sel[k])
                    user_upd[k*USER_WIDTH +: USER_WIDTH] <= user_sr;
            end
        end
    end

    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            case (state)
                SH_IR: begin
                    tdo    <= ir_sr[0];
                    tdo_en <= 1'b1;
                end
                SH_DR: begin
                    tdo    <= dr_lsb;
                    tdo_en <= 1'b1;
                end
                default: begin
                    tdo    <= 1'b0;
                    tdo_en <= 1'b0;
                end
            endcase
        end
    end
endmodule
